d_delay_line: RTL and testbench
===============================

Name: d_delay_line

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register chain with per-stage valid tracking.
- Supports hold, shift, broadcast-load and rotate modes, synchronous flush, a selectable output tap with complement, and an occupancy count.
- Serves as the generic pipeline-delay / retiming element in the memory datapath.

Parameters:
- WIDTH, 8, data width of each stage.
- DEPTH, 4, number of stages; legal range 1..256.
- RESET_VAL, 0, WIDTH-bit value loaded into every stage on reset and on flush.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  stage update enable; 0 means all stages hold.
- flush  input  1  synchronous clear of data and valid bits; overrides en and mode.
- mode  input  2  operating mode: 00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE.
- d  input  WIDTH  input data.
- d_valid  input  1  valid bit accompanying d.
- tap_sel  input  TW  output tap index, where TW = max(1, clog2(DEPTH)).
- q  output  WIDTH  data at the selected tap.
- qbar  output  WIDTH  bitwise complement of q.
- q_valid  output  1  valid bit of the selected tap.
- dout  output  WIDTH  last stage, stage[DEPTH-1].
- dout_valid  output  1  valid bit of the last stage.
- count  output  CW  number of valid stages, where CW = clog2(DEPTH+1).

Behaviour:
- State consists of stage[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1], and a registered count.
- Reset (rst_n=0, asynchronous):
  - stage[*] = RESET_VAL, vld[*] = 0, count = 0 immediately.
  - Consequently q = RESET_VAL, qbar = ~RESET_VAL, q_valid = 0, dout = RESET_VAL, dout_valid = 0.
  - Release is synchronous to the next clk edge; the first update occurs on the first rising edge with rst_n=1.
- Update priority at each rising edge: flush > (en=0) > mode.
- flush=1: every stage <= RESET_VAL, every vld <= 0, count <= 0. Applies regardless of en and mode.
- en=0 or mode=HOLD: all state holds.
- SHIFT:
  - stage[0] <= d, vld[0] <= d_valid.
  - stage[i] <= stage[i-1] and vld[i] <= vld[i-1] for i = 1..DEPTH-1.
  - The previous stage[DEPTH-1] is discarded.
  - Latency from d to tap k is k+1 edges; d to dout is DEPTH edges.
- LOAD: all stages <= d and all vld <= d_valid. Next count is DEPTH if d_valid=1, else 0.
- ROTATE:
  - stage[0] <= stage[DEPTH-1], vld[0] <= vld[DEPTH-1]; other stages shift as in SHIFT.
  - count is unchanged.
  - With DEPTH=1, ROTATE behaves as HOLD.
- count is always registered and equals the popcount of the next-state vld vector. It never exceeds DEPTH.
- Output tap:
  - q = stage[tap_sel] and q_valid = vld[tap_sel], decoded combinationally from registers. There is no path from d to q.
  - qbar = ~q at all times, including during reset.
  - tap_sel >= DEPTH (out of range): q = RESET_VAL, q_valid = 0. No X is ever driven.
- Boundary cases:
  - Shifting in d_valid=0 creates a bubble; count decrements when a valid word leaves stage[DEPTH-1] and no valid word enters.
  - Simultaneous entry and exit of valid words leaves count unchanged.
  - Assertion of rst_n mid-operation clears state within the same cycle, with no dependence on clk.
  - A mode change takes effect at the next edge; there is no pipelining of the mode input.
- The design has no combinational loops, no latches, and no gated clocks.

Test Plan:
1. Reset: drive rst_n=0 between clock edges with WIDTH=8, DEPTH=4, RESET_VAL=8'h00 -> q=8'h00, qbar=8'hFF, count=0, dout_valid=0 immediately, before any edge.
2. Shift fill/drain: mode=01, en=1, shift in 8'h11, 8'h22, 8'h33, 8'h44 all with d_valid=1, tap_sel=3 -> dout=8'h11 after edge 4 and count=4. Then shift with d_valid=0 for 4 edges -> count goes 3, 2, 1, 0.
3. Tap/complement: with the chain holding 11, 22, 33, 44 (stage0=44), sweep tap_sel 0..3 -> q = 44, 33, 22, 11 and qbar = BB, CC, DD, EE. Set tap_sel out of range (e.g. DEPTH=3 build, tap_sel=3) -> q=RESET_VAL, q_valid=0.
4. Load and rotate:
   - mode=10, d=8'hA5, d_valid=1 -> all stages hold A5 and count=4.
   - Then load stages with 1, 2, 3, 4 and apply mode=11 for 4 edges -> the original order returns after the fourth edge, count is constant, dout sequence is 3, 2, 1, 4.
5. Priority: with the chain full, assert flush=1 together with en=0 and mode=10 -> after 1 edge, all vld=0, count=0, q=RESET_VAL. With en=0 and mode=01 for 3 edges -> state unchanged.
6. Mid-operation reset: pulse rst_n low for 3 ns during a SHIFT stream -> state clears asynchronously. After release, the first captured word appears at stage0 on the first rising edge, and count=1.

Source files
------------

// File: rtl/d_delay_line.sv
// -----------------------------------------------------------------------------
// d_delay_line
//
// Purpose:
//   WIDTH-bit, DEPTH-stage register chain with a valid bit per stage. Used as
//   the generic pipeline-delay / retiming element of the memory datapath.
//   Supports HOLD, SHIFT, broadcast LOAD and ROTATE modes, a synchronous flush,
//   a selectable output tap (with complement) and a registered occupancy count.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      stage update enable (0 = all stages hold)
//   flush      in   1      synchronous clear of data/valid, beats en and mode
//   mode       in   2      00 HOLD, 01 SHIFT, 10 LOAD, 11 ROTATE
//   d          in   WIDTH  input data
//   d_valid    in   1      valid bit accompanying d
//   tap_sel    in   TW     output tap index
//   q          out  WIDTH  data at the selected tap (RESET_VAL if out of range)
//   qbar       out  WIDTH  bitwise complement of q
//   q_valid    out  1      valid bit at the selected tap (0 if out of range)
//   dout       out  WIDTH  last stage
//   dout_valid out  1      valid bit of the last stage
//   count      out  CW     number of valid stages
// -----------------------------------------------------------------------------
module d_delay_line #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int             CW        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             q_valid,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_SHIFT  = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_ROTATE = 2'b11;

    // The tap mux is padded to a power of two so every tap_sel value decodes
    // to a defined entry; unused entries read as RESET_VAL / invalid.
    localparam int TAPS = 1 << TW;

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_stage_next [DEPTH];
    logic [DEPTH-1:0] w_vld_next;
    logic [CW-1:0]    w_count_next;

    logic             w_hold;
    logic             w_shift;
    logic             w_load;
    logic             w_rotate;

    logic [WIDTH-1:0] w_tap_data [TAPS];
    logic [TAPS-1:0]  w_tap_vld;

    assign w_hold   = !en || (mode == MODE_HOLD);
    assign w_shift  = (mode == MODE_SHIFT);
    assign w_load   = (mode == MODE_LOAD);
    assign w_rotate = (mode == MODE_ROTATE);

    // Per-stage next-state selection. Stage 0 takes d on SHIFT and the last
    // stage on ROTATE; every other stage takes its predecessor in both modes.
    // With DEPTH=1 the ROTATE source of stage 0 is stage 0 itself, so ROTATE
    // degenerates to HOLD without special-casing.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] w_shift_d;
            logic             w_shift_v;
            logic [WIDTH-1:0] w_rot_d;
            logic             w_rot_v;

            if (gi == 0) begin : g_head
                assign w_shift_d = d;
                assign w_shift_v = d_valid;
                assign w_rot_d   = r_stage[DEPTH-1];
                assign w_rot_v   = r_vld[DEPTH-1];
            end else begin : g_body
                assign w_shift_d = r_stage[gi-1];
                assign w_shift_v = r_vld[gi-1];
                assign w_rot_d   = r_stage[gi-1];
                assign w_rot_v   = r_vld[gi-1];
            end

            assign w_stage_next[gi] = flush    ? RESET_VAL   :
                                      w_hold   ? r_stage[gi] :
                                      w_shift  ? w_shift_d   :
                                      w_load   ? d           :
                                      w_rotate ? w_rot_d     :
                                                 r_stage[gi];

            assign w_vld_next[gi]   = flush    ? 1'b0        :
                                      w_hold   ? r_vld[gi]   :
                                      w_shift  ? w_shift_v   :
                                      w_load   ? d_valid     :
                                      w_rotate ? w_rot_v     :
                                                 r_vld[gi];
        end
    endgenerate

    // Count is the popcount of the next valid vector, so it tracks every mode
    // (including flush and LOAD) without separate increment/decrement logic.
    always_comb begin
        w_count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + CW'(w_vld_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
            r_vld   <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= w_stage_next[i];
            end
            r_vld   <= w_vld_next;
            r_count <= w_count_next;
        end
    end

    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            if (gi < DEPTH) begin : g_real
                assign w_tap_data[gi] = r_stage[gi];
                assign w_tap_vld[gi]  = r_vld[gi];
            end else begin : g_pad
                assign w_tap_data[gi] = RESET_VAL;
                assign w_tap_vld[gi]  = 1'b0;
            end
        end
    endgenerate

    assign q          = w_tap_data[tap_sel];
    assign q_valid    = w_tap_vld[tap_sel];
    assign qbar       = ~q;
    assign dout       = r_stage[DEPTH-1];
    assign dout_valid = r_vld[DEPTH-1];
    assign count      = r_count;

endmodule

// File: tb/tb_d_delay_line.sv
// -----------------------------------------------------------------------------
// tb_d_delay_line
//
// Purpose:
//   Self-checking bench for d_delay_line. Two instances share the stimulus:
//   A (DEPTH=4, RESET_VAL=00) and B (DEPTH=3, RESET_VAL=3C, so tap_sel=3 is
//   out of range). Each is tracked by a queue-based reference model where
//   index 0 is stage 0 and the back of the queue is the last stage.
// -----------------------------------------------------------------------------
module tb_d_delay_line;

    localparam logic [7:0] RV_A = 8'h00;
    localparam logic [7:0] RV_B = 8'h3C;

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_SHIFT = 2'b01;
    localparam logic [1:0] M_LOAD  = 2'b10;
    localparam logic [1:0] M_ROT   = 2'b11;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       en      = 1'b0;
    logic       flush   = 1'b0;
    logic [1:0] mode    = 2'b00;
    logic [7:0] d       = 8'h00;
    logic       d_valid = 1'b0;
    logic [1:0] tap_a   = 2'd0;
    logic [1:0] tap_b   = 2'd0;

    logic [7:0] q_a, qbar_a, dout_a;
    logic       q_valid_a, dout_valid_a;
    logic [2:0] count_a;
    logic [7:0] q_b, qbar_b, dout_b;
    logic       q_valid_b, dout_valid_b;
    logic [1:0] count_b;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       vld;
    } ent_t;
    typedef ent_t ent_q_t[$];

    ent_q_t ma;
    ent_q_t mb;

    always #5 clk = ~clk;

    d_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .mode(mode),
        .d(d), .d_valid(d_valid), .tap_sel(tap_a),
        .q(q_a), .qbar(qbar_a), .q_valid(q_valid_a),
        .dout(dout_a), .dout_valid(dout_valid_a), .count(count_a)
    );

    d_delay_line #(.WIDTH(8), .DEPTH(3), .RESET_VAL(RV_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .mode(mode),
        .d(d), .d_valid(d_valid), .tap_sel(tap_b),
        .q(q_b), .qbar(qbar_b), .q_valid(q_valid_b),
        .dout(dout_b), .dout_valid(dout_valid_b), .count(count_b)
    );

    // ---------------- reference model ----------------
    function automatic ent_q_t model_clear(input int depth, input logic [7:0] rv);
        ent_q_t r;
        ent_t   e;
        r = {};
        e.data = rv;
        e.vld  = 1'b0;
        for (int i = 0; i < depth; i++) r.push_back(e);
        return r;
    endfunction

    function automatic ent_q_t model_step(input ent_q_t cur, input int depth,
                                          input logic [7:0] rv, input logic f,
                                          input logic e, input logic [1:0] m,
                                          input logic [7:0] dd, input logic dv);
        ent_q_t nxt;
        ent_t   t;
        nxt = cur;
        if (f) begin
            nxt = model_clear(depth, rv);
        end else if (e) begin
            case (m)
                M_SHIFT: begin
                    t.data = dd;
                    t.vld  = dv;
                    nxt.push_front(t);
                    t = nxt.pop_back();
                end
                M_LOAD: begin
                    nxt = {};
                    t.data = dd;
                    t.vld  = dv;
                    for (int i = 0; i < depth; i++) nxt.push_back(t);
                end
                M_ROT: begin
                    t = nxt.pop_back();
                    nxt.push_front(t);
                end
                default: ;
            endcase
        end
        return nxt;
    endfunction

    function automatic int model_count(input ent_q_t m);
        int n;
        n = 0;
        foreach (m[i]) if (m[i].vld) n++;
        return n;
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        ent_t       ea;
        ent_t       eb;
        logic [7:0] nq;
        ea = ma[tap_a];
        if (tap_b < 2'd3) begin
            eb = mb[tap_b];
        end else begin
            eb.data = RV_B;
            eb.vld  = 1'b0;
        end
        nq = ~ea.data;
        check_val("A.q",          q_a,          ea.data);
        check_val("A.qbar",       qbar_a,       nq);
        check_val("A.q_valid",    q_valid_a,    ea.vld);
        check_val("A.dout",       dout_a,       ma[3].data);
        check_val("A.dout_valid", dout_valid_a, ma[3].vld);
        check_val("A.count",      count_a,      model_count(ma));
        nq = ~eb.data;
        check_val("B.q",          q_b,          eb.data);
        check_val("B.qbar",       qbar_b,       nq);
        check_val("B.q_valid",    q_valid_b,    eb.vld);
        check_val("B.dout",       dout_b,       mb[2].data);
        check_val("B.dout_valid", dout_valid_b, mb[2].vld);
        check_val("B.count",      count_b,      model_count(mb));
    endtask

    task automatic cycle(input logic f, input logic e, input logic [1:0] m,
                         input logic [7:0] dd, input logic dv);
        flush   = f;
        en      = e;
        mode    = m;
        d       = dd;
        d_valid = dv;
        @(posedge clk);
        ma = model_step(ma, 4, RV_A, f, e, m, dd, dv);
        mb = model_step(mb, 3, RV_B, f, e, m, dd, dv);
        #1;
        $display("cyc t=%0t flush=%0d en=%0d mode=%0d d=%02h dv=%0d | A dout=%02h cnt=%0d | B dout=%02h cnt=%0d",
                 $time, f, e, m, dd, dv, dout_a, count_a, dout_b, count_b);
        check_all();
    endtask

    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        ma = model_clear(4, RV_A);
        mb = model_clear(3, RV_B);
        $display("rst t=%0t async reset asserted", $time);
        check_all();
        check_val("rst.count", count_a, 0);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] exp_q   [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic [7:0] exp_qb  [4] = '{8'hBB, 8'hCC, 8'hDD, 8'hEE};
    logic [7:0] exp_rot [4] = '{8'h03, 8'h02, 8'h01, 8'h04};
    logic [7:0] fill_v  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        // Reset asserted between edges: outputs must clear before any edge.
        #2;
        rst_n = 1'b0;
        #1;
        ma = model_clear(4, RV_A);
        mb = model_clear(3, RV_B);
        $display("rst t=%0t initial reset", $time);
        check_all();
        check_val("rst.q",          q_a,          8'h00);
        check_val("rst.qbar",       qbar_a,       8'hFF);
        check_val("rst.count",      count_a,      0);
        check_val("rst.dout_valid", dout_valid_a, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Shift fill
        tap_a = 2'd3;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, M_SHIFT, fill_v[i], 1'b1);
        check_val("fill.dout",  dout_a,  8'h11);
        check_val("fill.count", count_a, 4);

        // Tap sweep and complement
        for (int t = 0; t < 4; t++) begin
            tap_a = t[1:0];
            #1;
            $display("tap t=%0t tap_sel=%0d q=%02h qbar=%02h", $time, tap_a, q_a, qbar_a);
            check_all();
            check_val("tap.q",    q_a,    exp_q[t]);
            check_val("tap.qbar", qbar_a, exp_qb[t]);
        end
        tap_b = 2'd3;
        #1;
        $display("tap t=%0t B tap_sel=3 (out of range) q=%02h", $time, q_b);
        check_all();
        check_val("oor.q",       q_b,       RV_B);
        check_val("oor.q_valid", q_valid_b, 1'b0);

        // Drain with bubbles
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, M_SHIFT, 8'($urandom), 1'b0);
            check_val("drain.count", count_a, 3 - i);
        end

        // Broadcast load, then rotate
        cycle(1'b0, 1'b1, M_LOAD, 8'hA5, 1'b1);
        check_val("load.count", count_a, 4);
        for (int i = 4; i >= 1; i--) cycle(1'b0, 1'b1, M_SHIFT, 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, M_ROT, 8'($urandom), 1'b0);
            check_val("rot.dout",  dout_a,  exp_rot[i]);
            check_val("rot.count", count_a, 4);
        end

        // Priority: flush beats en=0 and LOAD
        tap_a = 2'd0;
        cycle(1'b1, 1'b0, M_LOAD, 8'hFF, 1'b1);
        check_val("flush.count", count_a, 0);
        check_val("flush.q",     q_a,     RV_A);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, M_SHIFT, 8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, M_SHIFT, 8'($urandom), 1'b1);
        check_val("en0.count", count_a, 4);

        // Mid-operation asynchronous reset
        cycle(1'b0, 1'b1, M_SHIFT, 8'h5E, 1'b1);
        async_reset_pulse();
        cycle(1'b0, 1'b1, M_SHIFT, 8'h77, 1'b1);
        check_val("post_rst.count", count_a, 1);
        check_val("post_rst.q",     q_a,     8'h77);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            tap_a = 2'($urandom_range(0, 3));
            tap_b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) async_reset_pulse();
            cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
